// File: rtl/fifo_wr_packer_pkg.sv
// Shared definitions for the dual-clock FIFO and its write-side packer.
`timescale 1ns/1ps
package fifo_wr_packer_pkg;

  // Pointer geometry of the dual-clock FIFO (extra MSB for wrap detection).
  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  // Default fill value for unused slots of an early-closed word.
  localparam int unsigned PAD_VAL_DEFAULT = 0;

  // Packer output-stage states.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,  // output register empty
    ST_PEND  = 2'd1,  // output register holds a word
    ST_STALL = 2'd2   // output and assembly registers both hold complete words
  } pack_state_t;

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs a narrow symbol stream LSB-first into FIFO words and drives the
// FIFO write port from registers, honouring the FIFO full flag.
`timescale 1ns/1ps
module fifo_wr_packer
  import fifo_wr_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SYM_WIDTH  = 2,
  parameter logic [SYM_WIDTH-1:0] PAD_VAL = SYM_WIDTH'(PAD_VAL_DEFAULT),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_wclk,
  input  logic                  i_rrstn,
  input  logic                  i_valid,
  input  logic [SYM_WIDTH-1:0]  i_sym,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_wfull,
  output logic [CNT_WIDTH-1:0]  o_wcount
);

  localparam int unsigned RATIO = DATA_WIDTH / SYM_WIDTH;
  localparam int unsigned CW    = $clog2(RATIO) + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

  pack_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_vld_q, out_vld_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  wcount_q;
  logic [DATA_WIDTH-1:0] word_new;
  logic                  accept, complete, drain;

  assign o_ready  = (state_q != ST_STALL);
  assign accept   = i_valid && o_ready;
  assign complete = accept && ((cnt_q == LAST_SLOT) || i_last);
  assign drain    = out_vld_q && !i_wfull;

  assign o_wr     = out_vld_q;
  assign o_wdata  = out_q;
  assign o_wcount = wcount_q;

  // Merge the incoming symbol into the assembly word; pad upper slots on completion.
  always_comb begin
    word_new = asm_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CW'(k) == cnt_q) begin
        word_new[k*SYM_WIDTH +: SYM_WIDTH] = i_sym;
      end else if ((CW'(k) > cnt_q) && complete) begin
        word_new[k*SYM_WIDTH +: SYM_WIDTH] = PAD_VAL;
      end
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    cnt_d     = cnt_q;
    if (accept) begin
      asm_d = word_new;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end
    case (state_q)
      ST_FILL: begin
        if (complete) begin
          out_d     = word_new;
          out_vld_d = 1'b1;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (complete && drain) begin
          out_d = word_new;
        end else if (complete) begin
          // Completed word stays parked in asm until the output drains.
          state_d = ST_STALL;
        end else if (drain) begin
          out_vld_d = 1'b0;
          state_d   = ST_FILL;
        end
      end
      ST_STALL: begin
        if (drain) begin
          out_d   = asm_q;
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d   = ST_FILL;
        out_vld_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_wclk or negedge i_rrstn) begin
    if (!i_rrstn) state_q <= ST_FILL;
    else          state_q <= state_d;
  end

  // Datapath registers and written-word counter.
  always_ff @(posedge i_wclk or negedge i_rrstn) begin
    if (!i_rrstn) begin
      asm_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
      wcount_q  <= '0;
    end else begin
      asm_q     <= asm_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
      if (drain) wcount_q <= wcount_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: expected words queued at issue time,
// checked by an independent monitor on each FIFO write transfer.
`timescale 1ns/1ps
module tb_fifo_wr_packer;

  logic        clk = 1'b0;
  logic        rstn, valid, last, wfull, ready, wr;
  logic [1:0]  sym;
  logic [7:0]  wdata;
  logic [15:0] wcount;

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_hi = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  fifo_wr_packer #(
    .DATA_WIDTH(8),
    .SYM_WIDTH (2),
    .PAD_VAL   (2'd0),
    .CNT_WIDTH (16)
  ) dut (
    .i_wclk  (clk),
    .i_rrstn (rstn),
    .i_valid (valid),
    .i_sym   (sym),
    .i_last  (last),
    .o_ready (ready),
    .o_wr    (wr),
    .o_wdata (wdata),
    .i_wfull (wfull),
    .o_wcount(wcount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one symbol and hold it until accepted (bounded).
  task automatic send(input logic [1:0] s, input logic l);
    logic r;
    int unsigned n = 0;
    valid = 1'b1;
    sym   = s;
    last  = l;
    do begin
      r = ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: symbol %0d not accepted within %0d cycles", s, n);
    end
  endtask

  task automatic idle(input int unsigned cycles);
    valid = 1'b0;
    last  = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every transfer on the FIFO write port pops and checks one expected word.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rstn === 1'b1) begin
      if (wr) wr_hi++;
      if (wr && !wfull) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h with no word expected", wdata);
        end else begin
          e = exp_q.pop_front();
          check("word_order", {24'd0, wdata}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    int w0;
    int unsigned guard;
    rstn  = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    sym   = 2'd0;
    wfull = 1'b0;
    #1;
    check("rst_wr", wr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wcount", wcount, 0);
    check("rst_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic packing: 1,2,3,0 -> 8'h39, one cycle after the 4th accept.
    exp_q.push_back(8'h39);
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    send(2'd3, 1'b0);
    send(2'd0, 1'b0);
    check("basic_wr", wr, 1);
    check("basic_wdata", wdata, 8'h39);
    idle(1);
    check("basic_wr_pulse", wr, 0);
    check("basic_wcount", wcount, 1);

    // Early close, then a following symbol lands in slot 0.
    exp_q.push_back(8'h03);
    send(2'd3, 1'b1);
    check("early_wdata", wdata, 8'h03);
    valid = 1'b0;
    last  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    last = 1'b0;
    exp_q.push_back(8'h02);
    send(2'd2, 1'b1);
    check("slot0_wdata", wdata, 8'h02);
    idle(2);
    check("early_wcount", wcount, 3);

    // Continuous stream of 16 symbols: four single-cycle write pulses.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hFF);
    w0 = wr_hi;
    for (int j = 0; j < 4; j++) begin
      for (int s = 0; s < 4; s++) begin
        send(2'(j), 1'b0);
        check("stream_ready", ready, 1);
      end
    end
    idle(3);
    check("stream_pulses", w0 + 4, wr_hi);
    check("stream_wcount", wcount, 7);

    // Backpressure: full held 20 cycles while 12 symbols are offered.
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h99);
    wfull = 1'b1;
    fork
      begin
        send(2'd3, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0); send(2'd0, 1'b0);
        send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd3, 1'b0); send(2'd3, 1'b0);
        send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0);
        valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 20; c++) begin
          @(posedge clk);
          #1;
          if (c >= 6 && c < 20) begin
            check("bp_hold_wdata", wdata, 8'h0F);
            check("bp_hold_wr", wr, 1);
          end
          if (c == 7)  check("bp_ready_before", ready, 1);
          if (c == 12) check("bp_ready_low", ready, 0);
          if (c == 20) wfull = 1'b0;
        end
      end
    join
    idle(6);
    check("bp_wcount", wcount, 10);

    // i_last on the final slot: no padding, no extra word.
    exp_q.push_back(8'h55);
    send(2'd1, 1'b0);
    send(2'd1, 1'b0);
    send(2'd1, 1'b0);
    send(2'd1, 1'b1);
    idle(3);
    check("lastfull_wcount", wcount, 11);
    check("lastfull_no_extra", wr, 0);

    // Reset with a stalled output word and a half-built word; both discarded.
    wfull = 1'b1;
    send(2'd3, 1'b0); send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd0, 1'b0);
    send(2'd1, 1'b0); send(2'd1, 1'b0);
    idle(1);
    check("prerst_wr", wr, 1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_wr", wr, 0);
    check("midrst_wcount", wcount, 0);
    check("midrst_wdata", wdata, 0);
    check("midrst_ready", ready, 1);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    wfull = 1'b0;
    exp_q.push_back(8'hAA);
    send(2'd2, 1'b0);
    send(2'd2, 1'b0);
    send(2'd2, 1'b0);
    send(2'd2, 1'b0);
    check("postrst_wdata", wdata, 8'hAA);
    idle(3);
    check("postrst_wcount", wcount, 1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side producer for the dual-clock FIFO, in the FIFO write clock domain. Accepts a narrow symbol stream over valid/ready and packs `RATIO = DATA_WIDTH/SYM_WIDTH` symbols LSB-first into one FIFO word. It drives the FIFO write port (`o_wr`/`o_wdata`) and obeys its registered full flag. A partial word is closed early on `i_last` and its empty slots are padded with `PAD_VAL`.

## Interface
- `DATA_WIDTH`, 8, FIFO word width; must equal the FIFO's `DATA_WIDTH`.
- `SYM_WIDTH`, 2, input symbol width; must divide `DATA_WIDTH` exactly.
- `PAD_VAL`, 0, `SYM_WIDTH`-bit value placed in unfilled slots of an early-closed word.
- `CNT_WIDTH`, 16, width of the written-word counter.

Ports:
- `i_wclk` in 1: clock (FIFO write clock).
- `i_rrstn` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: symbol valid.
- `i_sym` in `SYM_WIDTH`: symbol.
- `i_last` in 1: symbol closes the current word.
- `o_ready` out 1: symbol accepted on `i_valid && o_ready`.
- `o_wr` out 1: FIFO write request.
- `o_wdata` out `DATA_WIDTH`: FIFO write data.
- `i_wfull` in 1: FIFO full flag; a word transfers on `o_wr && !i_wfull`.
- `o_wcount` out `CNT_WIDTH`: words written since reset; wraps modulo 2^`CNT_WIDTH`.

## Operation
- Datapath:
  - Assembly register (`asm`) with slot count `cnt` (0..`RATIO`).
  - One-word output register (`out`, `out_vld`).
  - `o_wr = out_vld`, `o_wdata = out`, both driven from registers.
- Slot placement: the symbol accepted at slot k goes to `asm[k*SYM_WIDTH +: SYM_WIDTH]`.
- A word completes on an accept when `cnt == RATIO-1` or `i_last` is high. On completion:
  - Slots above the current one take `PAD_VAL`.
  - `cnt` returns to 0.
- Drain: `drain = out_vld && !i_wfull`. On `drain`, `o_wcount` increments.
- Load into `out` happens when a completed word exists and `!out_vld || drain`. The completed word is either completing this cycle or held complete in `asm`.
- States:
  - FILL: `out` empty. `o_ready=1`. Completion loads `out` → PEND.
  - PEND: `out` holds a word. `o_ready=1`.
    - Drain without completion → FILL.
    - Completion with drain → reload `out`, stay PEND.
    - Completion without drain → word held in `asm` → STALL.
  - STALL: `out` and `asm` both hold complete words. `o_ready=0`. Drain → `asm` moves to `out` → PEND.
- `o_ready` is combinational from state only, never from `i_valid` or `i_wfull`.
- No symbol is ever dropped or reordered. Words leave in completion order.
- `RATIO==1`: every accept completes a word. `i_last` has no effect.

## Timing
- Reset values, applied asynchronously:
  - `o_wr=0`, `o_wdata=0`, `o_wcount=0`, `o_ready=1`.
  - `cnt=0`, state FILL.
- Reset mid-word discards the partial `asm` and any pending `out`. The first symbol after release lands in slot 0.
- Latency: a symbol completing a word in cycle N gives `o_wr=1` with that word in cycle N+1.
- While `i_wfull=1`, `o_wr` and `o_wdata` are held stable until the transfer.
- The full flag deasserts late by design. The block needs no knowledge of this; it only requires that `i_wfull` is sampled on the same edge as `o_wr`.
- Throughput: one word per cycle when `RATIO==1`, otherwise one word per `RATIO` accepts. There are no bubbles while `i_wfull=0`.
- `i_last` on the symbol that fills slot `RATIO-1` gives no padding. The next word starts at slot 0.
- `i_last` with `!i_valid` or `!o_ready` is ignored.

## Structure
- State encodings (FILL/PEND/STALL) live in the shared FIFO package, next to the pointer-width constants used by the dual-clock FIFO.
- The `PAD_VAL` default also lives in that package.
- `RATIO` and `cnt` width are local derived constants: `$clog2(RATIO)+1`.
- Single module; no sub-module is natural. The top-level integration instantiates it directly in front of the dual-clock FIFO write port.

## Test plan
All scenarios use `DATA_WIDTH=8`, `SYM_WIDTH=2`, `PAD_VAL=0`.

- **Basic packing:** symbols 1,2,3,0 back-to-back with `i_wfull=0` → one `o_wr` pulse, cycle after the 4th accept, `o_wdata=8'h39`, `o_wcount=1`.
- **Early close:** single symbol 3 with `i_last=1` → `o_wdata=8'h03` on the next cycle. A following symbol lands in slot 0.
- **Stream throughput:** 16 symbols continuous, `i_wfull=0` → exactly 4 single-cycle `o_wr` pulses, `o_ready` never low, `o_wcount=4`.
- **Backpressure:** `i_wfull=1` held for 20 cycles while 12 symbols are offered →
  - `o_ready` drops after the second word completes.
  - `o_wdata` stays stable at the first word.
  - After release, 3 words are written in order with no loss.
- **Last on final slot:** symbols 1,1,1,1 with `i_last` on the 4th → `8'h55`, no extra padded word.
- **Reset mid-operation:** assert `i_rrstn=0` after 2 symbols of a word plus a pending stalled word →
  - `o_wr` falls immediately and `o_wcount=0`.
  - After release, symbols 2,2,2,2 produce `8'hAA`.
